// File: rtl/rra_pkg.sv
// rtl/rra_pkg.sv - shared types and ring/priority helpers for rr_ring_arbiter
// Helpers work on a fixed maximum width; callers pass the live width n.
package rra_pkg;

  localparam int RRA_MAX_N = 32;
  localparam int RRA_IDX_W = $clog2(RRA_MAX_N);

  typedef logic [RRA_MAX_N-1:0] rra_vec_t;
  typedef logic [RRA_IDX_W-1:0] rra_idx_t;

  typedef enum logic {IDLE, GRANT} rra_state_t;

  function automatic rra_vec_t rot_right(input rra_vec_t onehot, input int n);
    rra_vec_t res;
    res = onehot >> 1;
    if (onehot[0]) res[rra_idx_t'(n - 1)] = 1'b1;
    return res;
  endfunction

  // Descending search starting at the pointer bit, wrapping from 0 to n-1.
  function automatic rra_vec_t pick_winner(input rra_vec_t req, input rra_vec_t ptr, input int n);
    rra_vec_t res;
    int       k;
    int       idx;
    logic     found;
    res   = '0;
    k     = 0;
    found = 1'b0;
    for (int i = 0; i < RRA_MAX_N; i++) begin
      if (i < n && ptr[rra_idx_t'(i)]) k = i;
    end
    for (int j = 0; j < RRA_MAX_N; j++) begin
      if (j < n) begin
        idx = k - j;
        if (idx < 0) idx = idx + n;
        if (!found && req[rra_idx_t'(idx)]) begin
          res[rra_idx_t'(idx)] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rra_ring_ptr.sv
// rtl/rra_ring_ptr.sv - one-hot priority ring register, rotates right past the last owner
// Resets to the MSB; on advance it loads the rotate-right of the owner vector.
module rra_ring_ptr
  import rra_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         c,
  input  logic         r,
  input  logic         advance,
  input  logic [N-1:0] owner,
  output logic [N-1:0] ptr
);

  localparam logic [N-1:0] PTR_RST = {1'b1, {(N-1){1'b0}}};

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      ptr <= PTR_RST;
    end else if (advance) begin
      ptr <= N'(rot_right(RRA_MAX_N'(owner), N));
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// rtl/rr_ring_arbiter.sv - round-robin ring arbiter with hold-until-release grants
// Optional forced release after MAX_HOLD cycles when RRA_HOLD_TIMEOUT_EN is defined.
module rr_ring_arbiter
  import rra_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         c,
  input  logic         r,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic [N-1:0] ptr,
  output logic         timeout
);

  if (N < 2 || N > RRA_MAX_N || MAX_HOLD < 1) begin : g_param_check
    $error("rr_ring_arbiter: unsupported N or MAX_HOLD");
  end

  rra_state_t   state;
  logic [N-1:0] winner;
  logic         rel_normal;
  logic         hold_expire;
  logic         rel;

  rra_ring_ptr #(.N(N)) u_ring_ptr (
    .c       (c),
    .r       (r),
    .advance (rel),
    .owner   (gnt),
    .ptr     (ptr)
  );

`ifdef RRA_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  assign hold_expire = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign timeout     = timeout_q;
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    winner     = N'(pick_winner(RRA_MAX_N'(req), RRA_MAX_N'(ptr), N));
    rel_normal = (state == GRANT) && (done || ((req & gnt) == '0));
    rel        = rel_normal || hold_expire;
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
`ifdef RRA_HOLD_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RRA_HOLD_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req != '0) begin
            state <= GRANT;
            gnt   <= winner;
            busy  <= 1'b1;
`ifdef RRA_HOLD_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (rel) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
`ifdef RRA_HOLD_TIMEOUT_EN
            // A normal release in the same cycle takes precedence over the forced one.
            timeout_q <= !rel_normal;
`endif
          end else begin
`ifdef RRA_HOLD_TIMEOUT_EN
            hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb/tb_rr_ring_arbiter.sv - directed checks for rr_ring_arbiter (N=4, MAX_HOLD=8)
// Expectations follow RRA_HOLD_TIMEOUT_EN when it is defined for the build.
module tb_rr_ring_arbiter;

  logic       c;
  logic       r;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] ptr;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .c       (c),
    .r       (r),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .ptr     (ptr),
    .timeout (timeout)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  logic [3:0] gseq [4];
  logic [3:0] pseq [4];

  initial begin
    gseq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    pseq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    r = 1'b0; req = 4'b0000; done = 1'b0;
    #1 r = 1'b1;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", {3'b0, busy}, 4'b0000);
    chk("rst_ptr", ptr, 4'b1000);
    chk("rst_timeout", {3'b0, timeout}, 4'b0000);

    // Test 1: reset mid-cycle drops a live grant immediately
    tick();
    r = 1'b0; req = 4'b1111;
    tick();
    chk("t1_first_gnt", gnt, 4'b1000);
    chk("t1_first_busy", {3'b0, busy}, 4'b0001);
    #2 r = 1'b1;
    #1;
    chk("t1_async_gnt", gnt, 4'b0000);
    chk("t1_async_busy", {3'b0, busy}, 4'b0000);
    chk("t1_async_ptr", ptr, 4'b1000);
    r = 1'b0;
    tick();
    chk("t1_regrant", gnt, 4'b1000);

    // Test 2: full rotation with done pulses, dead cycle between owners
    for (int i = 0; i < 4; i++) begin
      done = 1'b1;
      tick();
      chk("t2_dead_gnt", gnt, 4'b0000);
      chk("t2_ptr", ptr, pseq[i]);
      done = 1'b0;
      tick();
      chk("t2_gnt", gnt, gseq[i]);
    end

    // Test 3: partial requests and pointer wrap
    req = 4'b0000; done = 1'b0;
    r = 1'b1;
    #2 r = 1'b0;
    chk("t3_ptr_start", ptr, 4'b1000);
    req = 4'b0011;
    tick();
    chk("t3_gnt1", gnt, 4'b0010);
    done = 1'b1;
    tick();
    chk("t3_ptr1", ptr, 4'b0001);
    chk("t3_dead", gnt, 4'b0000);
    done = 1'b0;
    tick();
    chk("t3_gnt0", gnt, 4'b0001);
    done = 1'b1;
    tick();
    chk("t3_ptr_wrap", ptr, 4'b1000);
    done = 1'b0;

    // Test 4: owner drops its request without done
    req = 4'b0100;
    tick();
    chk("t4_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    chk("t4_rel_gnt", gnt, 4'b0000);
    chk("t4_rel_ptr", ptr, 4'b0010);
    chk("t4_rel_timeout", {3'b0, timeout}, 4'b0000);
    chk("t4_rel_busy", {3'b0, busy}, 4'b0000);
    done = 1'b1;
    tick();
    chk("t4_idle_done_ptr", ptr, 4'b0010);
    chk("t4_idle_done_gnt", gnt, 4'b0000);
    done = 1'b0;

    // Test 5: reset during a grant, then search restarts from the MSB
    req = 4'b0010;
    tick();
    chk("t5_gnt", gnt, 4'b0010);
    r = 1'b1;
    #2;
    chk("t5_rst_gnt", gnt, 4'b0000);
    chk("t5_rst_ptr", ptr, 4'b1000);
    chk("t5_rst_timeout", {3'b0, timeout}, 4'b0000);
    r = 1'b0;
    tick();
    chk("t5_regrant", gnt, 4'b0010);
    chk("t5_regrant_ptr", ptr, 4'b1000);

    // done and req drop together: exactly one release
    req = 4'b0000; done = 1'b1;
    tick();
    chk("dual_rel_gnt", gnt, 4'b0000);
    chk("dual_rel_ptr", ptr, 4'b0001);
    done = 1'b0;
    tick();
    chk("dual_rel_ptr_hold", ptr, 4'b0001);

    // Other requests cannot steal a held grant
    req = 4'b0011;
    tick();
    chk("hold_gnt", gnt, 4'b0001);
    req = 4'b1111;
    tick();
    chk("hold_gnt_others", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("rel_owner0_ptr", ptr, 4'b1000);

    // Test 6: long hold
    req = 4'b0001;
    tick();
    chk("t6_gnt_start", gnt, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t6_gnt_hold", gnt, 4'b0001);
      chk("t6_timeout_low", {3'b0, timeout}, 4'b0000);
    end
`ifdef RRA_HOLD_TIMEOUT_EN
    tick();
    chk("t6_forced_gnt", gnt, 4'b0000);
    chk("t6_forced_timeout", {3'b0, timeout}, 4'b0001);
    chk("t6_forced_ptr", ptr, 4'b1000);
    tick();
    chk("t6_timeout_pulse_end", {3'b0, timeout}, 4'b0000);
    chk("t6_regrant", gnt, 4'b0001);
`else
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("t6_no_timeout_gnt", gnt, 4'b0001);
      chk("t6_no_timeout", {3'b0, timeout}, 4'b0000);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
